// File: rtl/aca_vl_ctrl.sv
// Approximate carry-window adder with optional exact recovery: a windowed
// approximation is evaluated in one cycle and, when flagged, redone group by group.
module aca_vl_ctrl #(
  parameter int WIDTH   = 16,
  parameter int VALENCY = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx_only,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   sum,
  output logic               cout,
  output logic               err_det,
  output logic [15:0]        err_count
);

  localparam int NG = WIDTH / VALENCY;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, RECOVER, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_r, b_r;
  logic               approx_r;
  logic [GW-1:0]      grp;
  logic               carry_r;

  logic [WIDTH-1:0]   p_r, g_r;
  logic [WIDTH:0]     apx_c;
  logic [WIDTH-1:0]   apx_sum;
  logic               apx_cy;
  logic               err_w;
  logic [VALENCY-1:0] rg_p, rg_g, rg_sum;
  logic               rg_cy;
  int                 lo;
  int                 grp_base;

  assign p_r = a_r ^ b_r;
  assign g_r = a_r & b_r;

  // Each carry only sees the VALENCY bits below it, with carry-in 0 at the window base.
  // NOTE: always_comb uses blocking assignments so each loop step sees the previous one.
  always_comb begin
    apx_c = '0;
    lo    = 0;
    for (int i = 1; i <= WIDTH; i++) begin
      lo     = (i > VALENCY) ? i - VALENCY : 0;
      apx_cy = 1'b0;
      for (int k = 0; k < VALENCY; k++) begin
        if (lo + k < i) apx_cy = g_r[lo+k] | (p_r[lo+k] & apx_cy);
      end
      apx_c[i] = apx_cy;
    end
    apx_sum = p_r ^ apx_c[WIDTH-1:0];
  end

  // A full-propagate run as long as the window means a truncated carry may be lost.
  always_comb begin
    err_w = 1'b0;
    for (int j = 1; j <= WIDTH - VALENCY; j++) begin
      if (&p_r[j +: VALENCY]) err_w = 1'b1;
    end
  end

  // One exact VALENCY-bit ripple group per RECOVER cycle, chained through carry_r.
  always_comb begin
    grp_base = int'(grp) * VALENCY;
    rg_p     = p_r[grp_base +: VALENCY];
    rg_g     = g_r[grp_base +: VALENCY];
    rg_sum   = '0;
    rg_cy    = carry_r;
    for (int k = 0; k < VALENCY; k++) begin
      rg_sum[k] = rg_p[k] ^ rg_cy;
      rg_cy     = rg_g[k] | (rg_p[k] & rg_cy);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      err_det   <= 1'b0;
      err_count <= '0;
      a_r       <= '0;
      b_r       <= '0;
      approx_r  <= 1'b0;
      grp       <= '0;
      carry_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            approx_r <= approx_only;
            in_ready <= 1'b0;
            state    <= EVAL;
          end
        end
        EVAL: begin
          err_det <= err_w;
          grp     <= '0;
          carry_r <= 1'b0;
          if (!err_w || approx_r) begin
            sum   <= apx_sum;
            cout  <= apx_c[WIDTH];
            state <= DONE;
          end else begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            state <= RECOVER;
          end
        end
        RECOVER: begin
          sum[grp_base +: VALENCY] <= rg_sum;
          carry_r                  <= rg_cy;
          grp                      <= grp + 1'b1;
          if (grp == GW'(NG - 1)) begin
            cout  <= rg_cy;
            state <= DONE;
          end
        end
        DONE: begin
          // out_valid rises one cycle after entering DONE; the handshake needs it high.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aca_vl_ctrl.md
ACA_VL_CTRL -- requirements
Module: aca_vl_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; multiple of VALENCY, at least 2*VALENCY.
REQ-002 SHALL have parameter VALENCY, default 4, carry-window size of the approximate adder and recovery group size.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand pair valid.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 approx_only  input  1  sampled with operands; 1 = skip exact recovery.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  WIDTH  result sum.
REQ-013 cout  output  1  result carry-out.
REQ-014 err_det  output  1  approximation flagged as possibly wrong for this result.
REQ-015 err_count  output  16  saturating count of recoveries performed.

Function
REQ-016 SHALL implement FSM states IDLE, EVAL, RECOVER, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready; on accept, a, b and approx_only are registered and state goes to EVAL.
REQ-018 Definitions: p = a^b, g = a&b; approximate carry into bit i (1..WIDTH) is the group generate of bits max(0,i-VALENCY)..i-1 with carry-in 0; cin of bit 0 is 0.
REQ-019 err_det SHALL be 1 iff some window j..j+VALENCY-1, j in 1..WIDTH-VALENCY, has all p bits 1.
REQ-020 In EVAL (one cycle): if err_det=0 or approx_only=1, sum/cout SHALL be loaded with the approximate result and state goes to DONE; otherwise state goes to RECOVER.
REQ-021 RECOVER SHALL take exactly WIDTH/VALENCY cycles, one VALENCY-bit group per cycle from LSB group upward, using that group's generate/propagate and the registered carry from the previous group; then DONE with exact sum and cout.
REQ-022 Latency: out_valid SHALL rise 2 edges after accept in the fast path and 2+WIDTH/VALENCY edges after accept in the recovery path.
REQ-023 In DONE, out_valid=1 and sum, cout, err_det SHALL hold stable until out_valid & out_ready, after which state returns to IDLE on the same edge.
REQ-024 err_det SHALL reflect REQ-019 for the current result, independent of approx_only.
REQ-025 err_count SHALL increment by 1 on each entry into RECOVER, saturating at 0xFFFF.
REQ-026 No new operands SHALL be accepted before the current result handshake completes; in_valid outside IDLE is ignored.

Reset
REQ-027 On rst=1 at a clock edge, in any state, state SHALL become IDLE; out_valid=0, in_ready=1, sum=0, cout=0, err_det=0, err_count=0; any in-flight operation is discarded.
REQ-028 rst SHALL take priority over accept and result handshakes occurring on the same edge.

Verification (WIDTH=16, VALENCY=4; accept at edge k)
REQ-029 a=0x0003, b=0x0005 -> out_valid at k+2, sum=0x0008, cout=0, err_det=0, err_count unchanged.
REQ-030 a=0x0FFF, b=0x0001, approx_only=0 -> out_valid at k+6, sum=0x1000, cout=0, err_det=1, err_count +1; same operands with approx_only=1 -> out_valid at k+2, sum=0x0FE0, cout=0, err_det=1, err_count unchanged.
REQ-031 a=0xFFFF, b=0x0001, approx_only=0 -> out_valid at k+6, sum=0x0000, cout=1, err_det=1.
REQ-032 Backpressure: out_ready=0 for 3 cycles after out_valid -> sum/cout/err_det stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-033 rst=1 while in RECOVER -> next edge out_valid=0, in_ready=1, sum=0, err_count=0; a following a=0x0001, b=0x0001 -> sum=0x0002 at k+2.
